wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: consecutive lost cycles before port 1 gains priority; range 1..7.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 p0_valid  in  1  pipeline writeback request.
REQ-005 p0_waddr  in  5  port 0 destination register.
REQ-006 p0_wdata  in  32  port 0 write data.
REQ-007 p0_ready  out  1  port 0 granted this cycle (combinational).
REQ-008 p1_valid  in  1  multi-cycle unit (div/load) writeback request.
REQ-009 p1_waddr  in  5  port 1 destination register.
REQ-010 p1_wdata  in  32  port 1 write data.
REQ-011 p1_ready  out  1  port 1 granted this cycle (combinational).
REQ-012 alloc_valid  in  1  decode marks a destination register as pending.
REQ-013 alloc_addr  in  5  register being allocated.
REQ-014 we  out  1  registered write enable to register file.
REQ-015 waddr  out  5  registered write address.
REQ-016 wdata  out  32  registered write data.
REQ-017 busy_vec  out  32  pending-write scoreboard, bit n = register n.
REQ-018 err_dup  out  1  sticky: allocation hit an already-busy register.

Function
REQ-019 At most one of p0_ready/p1_ready SHALL be high per cycle; a transfer occurs when valid and ready are both high.
REQ-020 Default priority: port 0 wins when both valid; port 1 granted when p0_valid low.
REQ-021 A 3-bit age counter SHALL increment each cycle p1_valid is high and p1 is not granted, saturating at STARVE_LIMIT.
REQ-022 When age == STARVE_LIMIT, port 1 SHALL win over port 0 that cycle; age clears to 0 on any port 1 grant or when p1_valid is low.
REQ-023 ready SHALL never be high for a port whose valid is low; ready does not depend on the port's own data.
REQ-024 A transfer in cycle N SHALL drive we=1, waddr, wdata of the winner during cycle N+1; with no transfer in N, we=0 in N+1 and waddr/wdata hold.
REQ-025 A transfer with waddr==0 SHALL be accepted (ready high) but produce we=0 in N+1.
REQ-026 busy_vec bit n SHALL set on the edge after alloc_valid with alloc_addr==n, n!=0; bit 0 is constant 0.
REQ-027 busy_vec bit n SHALL clear on the edge ending the cycle in which we=1 and waddr==n.
REQ-028 Same edge set and clear of one bit: set wins (bit stays 1).
REQ-029 alloc_valid to a register whose bit is already 1 and not being cleared that edge SHALL set err_dup; err_dup clears only on reset.
REQ-030 Grant decisions SHALL use busy_vec/age state only as registered values; no combinational path from we to p*_ready.

Reset
REQ-031 rst high SHALL immediately force we=0, waddr=0, wdata=0, busy_vec=0, age=0, err_dup=0, p0_ready=0, p1_ready=0.
REQ-032 Reset asserted mid-transfer SHALL discard the pending write; no we pulse after reset deassertion without a new transfer.
REQ-033 First grant possible in the first cycle with rst low.

Verification
V1 p0 valid addr 5 data 0xA5A5A5A5 alone -> p0_ready=1 same cycle; next cycle we=1, waddr=5, wdata=0xA5A5A5A5.
V2 p0 and p1 continuously valid, STARVE_LIMIT=3 -> p0 granted 3 cycles, p1 granted 4th cycle, pattern repeats.
V3 alloc r7, then p1 writes r7 -> busy_vec[7]=1 until edge ending we cycle, then 0; same-edge re-alloc r7 keeps bit 1.
V4 p0 write to r0 -> p0_ready=1, next cycle we=0; alloc r0 -> busy_vec stays 0.
V5 alloc r3 twice without intervening write -> err_dup=1 and held until rst.
V6 rst asserted asynchronously during cycle N+1 of a grant -> we drops to 0 immediately, busy_vec=0, no write after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bundle of writeback request ports, allocation port and register-file write
// outputs shared between the writeback arbiter and its environment.
interface wb_arbiter_if;
  logic        p0_valid;
  logic [4:0]  p0_waddr;
  logic [31:0] p0_wdata;
  logic        p0_ready;
  logic        p1_valid;
  logic [4:0]  p1_waddr;
  logic [31:0] p1_wdata;
  logic        p1_ready;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy_vec;
  logic        err_dup;

  modport master (
    output p0_valid, p0_waddr, p0_wdata,
    output p1_valid, p1_waddr, p1_wdata,
    output alloc_valid, alloc_addr,
    input  p0_ready, p1_ready,
    input  we, waddr, wdata, busy_vec, err_dup
  );

  modport slave (
    input  p0_valid, p0_waddr, p0_wdata,
    input  p1_valid, p1_waddr, p1_wdata,
    input  alloc_valid, alloc_addr,
    output p0_ready, p1_ready,
    output we, waddr, wdata, busy_vec, err_dup
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter with starvation guard for the
// multi-cycle port and a pending-write scoreboard.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam logic [2:0] AGE_MAX = 3'(STARVE_LIMIT);

  logic [2:0]  age_q, age_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;

  logic        grant0, grant1, xfer;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        dup_hit;

  // Grants depend only on valids and the registered age, never on data or we.
  always_comb begin
    grant1   = ~rst & bus.p1_valid & (~bus.p0_valid | (age_q == AGE_MAX));
    grant0   = ~rst & bus.p0_valid & ~grant1;
    xfer     = grant0 | grant1;
    sel_addr = grant1 ? bus.p1_waddr : bus.p0_waddr;
    sel_data = grant1 ? bus.p1_wdata : bus.p0_wdata;

    age_d = age_q;
    if (!bus.p1_valid || grant1) begin
      age_d = 3'd0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 3'd1;
    end

    we_d    = xfer && (sel_addr != 5'd0);
    waddr_d = xfer ? sel_addr : waddr_q;
    wdata_d = xfer ? sel_data : wdata_q;
  end

  assign bus.p0_ready = grant0;
  assign bus.p1_ready = grant1;

  // A set and a clear landing on the same edge leave the bit set.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_d[gi] = (bus.alloc_valid && (bus.alloc_addr == 5'(gi))) |
                          (busy_q[gi] & ~(we_q && (waddr_q == 5'(gi))));
    end
  endgenerate

  always_comb begin
    dup_hit = bus.alloc_valid && (bus.alloc_addr != 5'd0) &&
              busy_q[bus.alloc_addr] &&
              !(we_q && (waddr_q == bus.alloc_addr));
    err_d   = err_q | dup_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q   <= 3'd0;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      busy_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      age_q   <= age_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.busy_vec = busy_q;
  assign bus.err_dup  = err_q;

endmodule
